// File: rtl/uart_frame_loader_pkg.sv
// uart_frame_loader_pkg: shared types and frame geometry for the serial frame loader.
//   state_t    : loader FSM states
//   rx_state_t : serial receiver states
//   row_t      : one matrix row word, [.RGB.RGB] x4
package uart_frame_loader_pkg;
   typedef enum logic [1:0] {HUNT, COLLECT, CHECK, WRITE} state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
   localparam int FRAME_ROWS    = 8;
   localparam int BYTES_PER_ROW = 4;
   localparam int FRAME_BYTES   = FRAME_ROWS * BYTES_PER_ROW;
   typedef logic [31:0] row_t;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial byte receiver with 2-flop synchroniser and framing check.
//   clk, reset_n : clock, synchronous active-low reset
//   rx           : asynchronous serial line, idle high
//   rx_valid     : one-cycle strobe, rx_byte holds the received byte
//   rx_byte      : last received byte
//   rx_ferr      : one-cycle strobe when a stop bit is sampled low
module uart_rx
   import uart_frame_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1302
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       rx_ferr
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   rx_state_t state, state_nxt;
   logic rx_meta, rx_sync, rx_prev;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0] bit_idx, bit_idx_nxt;
   logic [7:0] shreg, shreg_nxt;
   logic valid_nxt, ferr_nxt;
   assign rx_byte = shreg;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         {rx_meta, rx_sync, rx_prev} <= 3'b111;
         state    <= RX_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         {rx_meta, rx_sync, rx_prev} <= {rx, rx_meta, rx_sync};
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         shreg    <= shreg_nxt;
         rx_valid <= valid_nxt;
         rx_ferr  <= ferr_nxt;
      end
   end
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt + 1'b1;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      valid_nxt   = 1'b0;
      ferr_nxt    = 1'b0;
      case (state)
         RX_IDLE: begin
            cnt_nxt = '0;
            if (rx_prev && !rx_sync) state_nxt = RX_START;
         end
         // a start bit that is high again at mid-bit was a glitch
         RX_START: if (cnt == HALF_LAST) begin
            cnt_nxt     = '0;
            bit_idx_nxt = '0;
            state_nxt   = rx_sync ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (cnt == BIT_LAST) begin
            cnt_nxt     = '0;
            shreg_nxt   = {rx_sync, shreg[7:1]};
            bit_idx_nxt = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_nxt = RX_STOP;
         end
         RX_STOP: if (cnt == BIT_LAST) begin
            cnt_nxt   = '0;
            valid_nxt = rx_sync;
            ferr_nxt  = !rx_sync;
            state_nxt = rx_sync ? RX_IDLE : RX_BREAK;
         end
         // after a framing error, wait for the line to go idle before hunting again
         RX_BREAK: begin
            cnt_nxt = '0;
            if (rx_sync) state_nxt = RX_IDLE;
         end
         default: state_nxt = RX_IDLE;
      endcase
   end
endmodule

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: receives 8x8 RGB frames over 8N1 serial and bursts them to the matrix over pipelined wishbone.
//   clk, reset_n        : clock, synchronous active-low reset
//   i_rx                : serial input, idle high; frame = SYNC_BYTE + 32 data bytes
//   o_wb_*              : wishbone master, one 8-row pipelined write burst per frame
//   i_wb_ack/stall      : slave handshake; i_wb_rdata is not used
//   o_frame_done        : one-cycle pulse after the 8th ack of a burst
//   o_err               : one-cycle pulse on framing error, timeout or checksum mismatch
//   o_busy              : high whenever the loader is not hunting for a sync byte
// Build option: define UART_FRAME_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_frame_loader
   import uart_frame_loader_pkg::*;
#(
   parameter int         CLK_HZ       = 150000000,
   parameter int         BAUD         = 115200,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter int         TIMEOUT_CLKS = 4 * 10 * (CLK_HZ / BAUD)
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_rx,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [2:0]  o_wb_addr,
   output logic [3:0]  o_wb_sel,
   output logic [31:0] o_wb_wdata,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   input  logic [31:0] i_wb_rdata,
   output logic        o_frame_done,
   output logic        o_err,
   output logic        o_busy
);
   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int IW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CLKS - 1);
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
   localparam state_t AFTER_DATA = CHECK;
`else
   localparam state_t AFTER_DATA = WRITE;
`endif
   state_t state, state_nxt;
   logic rx_valid, rx_ferr;
   logic [7:0] rx_byte;
   logic [4:0] byte_cnt;
   logic [3:0] row_cnt, ack_cnt;
   logic [IW-1:0] idle_cnt;
   row_t frame_mem [FRAME_ROWS];
   logic err_nxt, done_nxt, accept, ack_hit, timeout, rdata_unused;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
   logic [7:0] csum;
`endif
   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk      (clk),
      .reset_n  (reset_n),
      .rx       (i_rx),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .rx_ferr  (rx_ferr)
   );
   assign rdata_unused = ^i_wb_rdata;
   // row_cnt counts accepted rows; bit 3 set means all 8 rows are out
   assign o_wb_cyc   = state == WRITE;
   assign o_wb_stb   = o_wb_cyc && !row_cnt[3];
   assign o_wb_we    = o_wb_stb;
   assign o_wb_sel   = {4{o_wb_stb}};
   assign o_wb_addr  = row_cnt[2:0];
   assign o_wb_wdata = o_wb_stb ? frame_mem[row_cnt[2:0]] : '0;
   assign o_busy     = state != HUNT;
   assign accept     = o_wb_stb && !i_wb_stall;
   assign ack_hit    = o_wb_cyc && i_wb_ack;
   assign timeout    = idle_cnt == IDLE_LAST;
   always_comb begin
      state_nxt = state;
      err_nxt   = rx_ferr;
      done_nxt  = 1'b0;
      case (state)
         HUNT: if (rx_valid && rx_byte == SYNC_BYTE) state_nxt = COLLECT;
         // a byte arriving on the timeout cycle takes priority over the timeout
         COLLECT: if (rx_valid) begin
            if (byte_cnt == 5'(FRAME_BYTES - 1)) state_nxt = AFTER_DATA;
         end else if (timeout) begin
            err_nxt   = 1'b1;
            state_nxt = HUNT;
         end
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
         CHECK: if (rx_valid) begin
            err_nxt   = rx_byte != csum;
            state_nxt = rx_byte == csum ? WRITE : HUNT;
         end else if (timeout) begin
            err_nxt   = 1'b1;
            state_nxt = HUNT;
         end
`endif
         WRITE: if (ack_hit && ack_cnt == 4'd7) begin
            done_nxt  = 1'b1;
            state_nxt = HUNT;
         end
         default: state_nxt = HUNT;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= HUNT;
         byte_cnt     <= '0;
         row_cnt      <= '0;
         ack_cnt      <= '0;
         idle_cnt     <= '0;
         o_err        <= 1'b0;
         o_frame_done <= 1'b0;
      end else begin
         state        <= state_nxt;
         o_err        <= err_nxt;
         o_frame_done <= done_nxt;
         byte_cnt     <= state != COLLECT ? '0 : byte_cnt + 5'(rx_valid);
         idle_cnt     <= (state inside {COLLECT, CHECK}) && !rx_valid ? idle_cnt + 1'b1 : '0;
         row_cnt      <= o_wb_cyc ? row_cnt + 4'(accept) : '0;
         ack_cnt      <= o_wb_cyc ? ack_cnt + 4'(ack_hit) : '0;
      end
   end
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!reset_n || state == HUNT) csum <= '0;
      else if (state == COLLECT && rx_valid) csum <= csum ^ rx_byte;
   end
`endif
   // first byte of a row lands in bits [31:24]
   always_ff @(posedge clk) begin
      if (state == COLLECT && rx_valid) frame_mem[byte_cnt[4:2]][{~byte_cnt[1:0], 3'b000} +: 8] <= rx_byte;
   end
endmodule
